port_access_ctrl: RTL and testbench
===================================

// Module: port_access_ctrl
// PURPOSE
//  Owns the PORTA/B/C output latches and TRIS registers and arbitrates write/read access to them
//  between the core (strobed by execute-stage decode) and a debug host (four-phase req/ack channel).
//  Synchronizes pin inputs and provides the core's port read value. Sits between the execute unit,
//  the debug interface and the chip pad ring. Core always has priority; debug access never stalls the core.
// PARAMETERS
//  IO_A_WIDTH   4  PORTA width (bits); B and C are fixed at 8
//  SYNC_STAGES  2  pin-input synchronizer depth (>=2)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  cpu_wr_tris  in   1   core TRIS write strobe (one clk pulse)
//  cpu_wr_port  in   1   core PORT latch write strobe (one clk pulse)
//  cpu_sel      in   2   core target: 01=A 10=B 11=C 00=none
//  cpu_wdata    in   8   core write data (W register)
//  cpu_rdata    out  8   core port read value for cpu_sel (combinational)
//  dbg_req      in   1   debug request (level, four-phase)
//  dbg_we       in   1   debug write(1)/read(0), valid with dbg_req rising
//  dbg_addr     in   3   0/1/2=latch A/B/C, 4/5/6=TRIS A/B/C, 3/7 invalid
//  dbg_wdata    in   8   debug write data
//  dbg_ack      out  1   debug completion, one-clk pulse
//  dbg_rdata    out  8   debug read data, held until next completion
//  dbg_err      out  1   invalid address on last completion, held
//  pin_a/b/c    in   IO_A_WIDTH/8/8  asynchronous pad inputs
//  port_a/b/c   out  IO_A_WIDTH/8/8  output latches to pads
//  tris_a/b/c   out  IO_A_WIDTH/8/8  output-enable, 1=input (hi-Z)
// BEHAVIOUR
//  Reset (async): tris_* all ones, port_* 0, sync flops 0, dbg_ack/dbg_rdata/dbg_err 0, FSM IDLE.
//  Core writes: commit on the edge where the strobe is high; cpu_sel=00 ignored; A takes cpu_wdata[IO_A_WIDTH-1:0].
//   cpu_wr_tris and cpu_wr_port together in one clk: both commit.
//  cpu_rdata bit i = tris?i : pin_sync[i] : port[i]; PORTA zero-extended to 8; cpu_sel=00 -> 8'h00.
//  Pin sync: SYNC_STAGES flops per bit; pin change visible on cpu_rdata after SYNC_STAGES edges.
//  Debug FSM: IDLE -> ACCESS -> ACK -> RELEASE -> IDLE.
//   IDLE: dbg_req=1 -> capture dbg_we/dbg_addr/dbg_wdata, go ACCESS.
//   ACCESS: conflict = core strobe this clk targeting the same register as captured addr -> stay
//    (core write wins). Else: write commits / read captures register value into dbg_rdata
//    (read zero-extends A), dbg_err<=0, go ACK. Invalid addr: no write, dbg_rdata<=0, dbg_err<=1, go ACK.
//    Core write to a different register in the same clk commits alongside the debug write.
//   ACK: dbg_ack=1 for exactly this clk, go RELEASE.
//   RELEASE: wait dbg_req=0, then IDLE. dbg_req low earlier than ACK does not abort the access.
//  Latency: dbg_req sampled at edge N, no conflict -> write visible after edge N+1, dbg_ack high N+2..N+3.
//  Core strobes at most once per 4 clk, so a conflicted debug access completes within 1 extra clk.
//  Debug read of a register the core writes in the ACCESS clk returns the post-write value (deferred by conflict rule).
//  Reset mid-transaction: aborts, no ack; if dbg_req still high after reset, a new transaction starts.
// TESTING
//  Reset -> tris_a=4'hF, tris_b=tris_c=8'hFF, port_*=0, dbg_ack=0; check with rst asserted asynchronously mid-clk.
//  Core cpu_wr_tris, cpu_sel=10, cpu_wdata=8'h0F -> tris_b=8'h0F next edge; cpu_sel=00 write -> no change.
//  pin_b=8'hA5, port_b=8'h3C, tris_b=8'h0F, cpu_sel=10 -> cpu_rdata=8'h35 after 2 edges.
//  Debug write addr 5 data 8'h55, no core activity -> tris_b=8'h55 at N+1, one-clk dbg_ack at N+2.
//  Debug write addr 1 data 8'h11 with core cpu_wr_port B 8'h22 in ACCESS clk -> port_b=8'h22 then 8'h11, ack 1 clk late.
//  Debug read addr 7 -> dbg_ack pulse, dbg_err=1, dbg_rdata=0, no register changes; hold dbg_req high -> no second ack.

Source files
------------

// File: rtl/port_access_ctrl.sv
// PORTA/B/C latch and TRIS ownership with core-priority arbitration against a
// four-phase debug host channel, plus pad-input synchronizers for port reads.
module port_access_ctrl #(
  parameter int IO_A_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_wr_tris,
  input  logic                  cpu_wr_port,
  input  logic [1:0]            cpu_sel,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [2:0]            dbg_addr,
  input  logic [7:0]            dbg_wdata,
  output logic                  dbg_ack,
  output logic [7:0]            dbg_rdata,
  output logic                  dbg_err,
  input  logic [IO_A_WIDTH-1:0] pin_a,
  input  logic [7:0]            pin_b,
  input  logic [7:0]            pin_c,
  output logic [IO_A_WIDTH-1:0] port_a,
  output logic [7:0]            port_b,
  output logic [7:0]            port_c,
  output logic [IO_A_WIDTH-1:0] tris_a,
  output logic [7:0]            tris_b,
  output logic [7:0]            tris_c
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } dbg_state_t;

  dbg_state_t state_reg, state_next;

  logic       cap_we_reg;
  logic [2:0] cap_addr_reg;
  logic [7:0] cap_wdata_reg;
  logic       dbg_ack_reg;
  logic [7:0] dbg_rdata_reg;
  logic       dbg_err_reg;

  // Register map index: 0..2 = latch A/B/C, 4..6 = TRIS A/B/C
  logic [7:0] core_hit;
  logic       conflict;
  logic       addr_valid;
  logic       dbg_done;
  logic [7:0] rd_val;

  logic [7:0] latch_q  [3];
  logic [7:0] tris_q   [3];
  logic [7:0] read_val [3];
  logic [7:0] pin_bus  [3];

  assign pin_bus[0] = 8'(pin_a);
  assign pin_bus[1] = pin_b;
  assign pin_bus[2] = pin_c;

  assign core_hit[3] = 1'b0;
  assign core_hit[7] = 1'b0;

  assign addr_valid = (cap_addr_reg[1:0] != 2'd3);
  assign conflict   = (state_reg == ACCESS) && core_hit[cap_addr_reg];
  assign dbg_done   = (state_reg == ACCESS) && !conflict;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_reg
      // Bits above IO_A_WIDTH in PORTA storage stay zero so reads zero-extend
      localparam logic [7:0] MASK = (gi == 0) ? 8'((1 << IO_A_WIDTH) - 1) : 8'hFF;

      logic [7:0] latch_reg;
      logic [7:0] tris_reg;
      logic [7:0] sync_reg [SYNC_STAGES];
      logic       core_port_hit;
      logic       core_tris_hit;
      logic       dbg_port_hit;
      logic       dbg_tris_hit;

      assign core_port_hit = cpu_wr_port && (cpu_sel == 2'(gi + 1));
      assign core_tris_hit = cpu_wr_tris && (cpu_sel == 2'(gi + 1));
      assign dbg_port_hit  = dbg_done && cap_we_reg && (cap_addr_reg == 3'(gi));
      assign dbg_tris_hit  = dbg_done && cap_we_reg && (cap_addr_reg == 3'(gi + 4));

      assign core_hit[gi]     = core_port_hit;
      assign core_hit[gi + 4] = core_tris_hit;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          latch_reg <= 8'h00;
          tris_reg  <= MASK;
        end else begin
          if (core_port_hit)
            latch_reg <= cpu_wdata & MASK;
          else if (dbg_port_hit)
            latch_reg <= cap_wdata_reg & MASK;
          if (core_tris_hit)
            tris_reg <= cpu_wdata & MASK;
          else if (dbg_tris_hit)
            tris_reg <= cap_wdata_reg & MASK;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SYNC_STAGES; s++)
            sync_reg[s] <= 8'h00;
        end else begin
          sync_reg[0] <= pin_bus[gi] & MASK;
          for (int s = 1; s < SYNC_STAGES; s++)
            sync_reg[s] <= sync_reg[s-1];
        end
      end

      assign latch_q[gi]  = latch_reg;
      assign tris_q[gi]   = tris_reg;
      assign read_val[gi] = ((tris_reg & sync_reg[SYNC_STAGES-1]) |
                             (~tris_reg & latch_reg)) & MASK;
    end
  endgenerate

  always_comb begin
    cpu_rdata = 8'h00;
    case (cpu_sel)
      2'b01:   cpu_rdata = read_val[0];
      2'b10:   cpu_rdata = read_val[1];
      2'b11:   cpu_rdata = read_val[2];
      default: cpu_rdata = 8'h00;
    endcase
  end

  always_comb begin
    rd_val = 8'h00;
    case (cap_addr_reg)
      3'd0:    rd_val = latch_q[0];
      3'd1:    rd_val = latch_q[1];
      3'd2:    rd_val = latch_q[2];
      3'd4:    rd_val = tris_q[0];
      3'd5:    rd_val = tris_q[1];
      3'd6:    rd_val = tris_q[2];
      default: rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (dbg_req) state_next = ACCESS;
      ACCESS:  if (!conflict) state_next = ACK;
      ACK:     state_next = RELEASE;
      RELEASE: if (!dbg_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cap_we_reg    <= 1'b0;
      cap_addr_reg  <= 3'd0;
      cap_wdata_reg <= 8'h00;
      dbg_ack_reg   <= 1'b0;
      dbg_rdata_reg <= 8'h00;
      dbg_err_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dbg_ack_reg <= (state_reg == ACK);
      if (state_reg == IDLE && dbg_req) begin
        cap_we_reg    <= dbg_we;
        cap_addr_reg  <= dbg_addr;
        cap_wdata_reg <= dbg_wdata;
      end
      // Writes leave dbg_rdata holding the previous read result
      if (dbg_done) begin
        if (!addr_valid) begin
          dbg_rdata_reg <= 8'h00;
          dbg_err_reg   <= 1'b1;
        end else begin
          dbg_err_reg <= 1'b0;
          if (!cap_we_reg)
            dbg_rdata_reg <= rd_val;
        end
      end
    end
  end

  assign dbg_ack   = dbg_ack_reg;
  assign dbg_rdata = dbg_rdata_reg;
  assign dbg_err   = dbg_err_reg;

  assign port_a = latch_q[0][IO_A_WIDTH-1:0];
  assign port_b = latch_q[1];
  assign port_c = latch_q[2];
  assign tris_a = tris_q[0][IO_A_WIDTH-1:0];
  assign tris_b = tris_q[1];
  assign tris_c = tris_q[2];

endmodule

// File: tb/tb_port_access_ctrl.sv
// Directed bench for port_access_ctrl: reset, core writes/reads, pin sync,
// debug write/read/invalid accesses, core conflict and reset mid-transaction.
module tb_port_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_wr_tris, cpu_wr_port;
  logic [1:0] cpu_sel;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       dbg_req, dbg_we;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic       dbg_ack, dbg_err;
  logic [3:0] pin_a, port_a, tris_a;
  logic [7:0] pin_b, pin_c, port_b, port_c, tris_b, tris_c;

  int errors = 0;
  int checks = 0;

  port_access_ctrl #(.IO_A_WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_wr_tris(cpu_wr_tris), .cpu_wr_port(cpu_wr_port),
    .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dbg_err(dbg_err),
    .pin_a(pin_a), .pin_b(pin_b), .pin_c(pin_c),
    .port_a(port_a), .port_b(port_b), .port_c(port_c),
    .tris_a(tris_a), .tris_b(tris_b), .tris_c(tris_c)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_start(input logic we, input logic [2:0] addr, input logic [7:0] data);
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = data;
  endtask

  initial begin
    rst = 1'b1;
    cpu_wr_tris = 0; cpu_wr_port = 0; cpu_sel = 2'b00; cpu_wdata = 8'h00;
    dbg_req = 0; dbg_we = 0; dbg_addr = 3'd0; dbg_wdata = 8'h00;
    pin_a = 4'h0; pin_b = 8'h00; pin_c = 8'h00;
    repeat (2) tick;
    rst = 1'b0;
    tick;

    // Reset state
    check_val("rst_tris_a", 32'(tris_a), 32'hF);
    check_val("rst_tris_b", 32'(tris_b), 32'hFF);
    check_val("rst_tris_c", 32'(tris_c), 32'hFF);
    check_val("rst_ports", {8'h0, 4'(port_a), port_b, port_c}, 32'h0);
    check_val("rst_dbg", {dbg_ack, dbg_err, dbg_rdata}, 32'h0);
    check_val("rst_rdata_sel0", 32'(cpu_rdata), 32'h0);

    // Core TRIS write to B
    cpu_wr_tris = 1; cpu_sel = 2'b10; cpu_wdata = 8'h0F;
    tick;
    cpu_wr_tris = 0;
    check_val("core_tris_b", 32'(tris_b), 32'h0F);

    // Write with cpu_sel=00 is ignored
    cpu_sel = 2'b00; cpu_wr_port = 1; cpu_wr_tris = 1; cpu_wdata = 8'hFF;
    tick;
    cpu_wr_port = 0; cpu_wr_tris = 0;
    check_val("sel0_ports", {8'h0, 4'(port_a), port_b, port_c}, 32'h0);
    check_val("sel0_tris", {4'h0, tris_a, tris_b, tris_c}, 32'h0F0FFF);

    // Simultaneous TRIS and PORT write to A, truncated to 4 bits
    cpu_sel = 2'b01; cpu_wr_port = 1; cpu_wr_tris = 1; cpu_wdata = 8'hA7;
    tick;
    cpu_wr_port = 0; cpu_wr_tris = 0;
    check_val("both_port_a", 32'(port_a), 32'h7);
    check_val("both_tris_a", 32'(tris_a), 32'h7);
    pin_a = 4'h9;
    repeat (2) tick;
    check_val("rdata_a", 32'(cpu_rdata), 32'h01);

    // Port B read mixing pins and latch, through the synchronizer
    cpu_sel = 2'b10; cpu_wr_port = 1; cpu_wdata = 8'h3C;
    tick;
    cpu_wr_port = 0;
    pin_b = 8'hA5;
    check_val("rdata_b_pre", 32'(cpu_rdata), 32'h30);
    tick;
    check_val("rdata_b_1edge", 32'(cpu_rdata), 32'h30);
    tick;
    check_val("rdata_b_2edge", 32'(cpu_rdata), 32'h35);

    // Debug write TRIS B, no core activity
    dbg_start(1'b1, 3'd5, 8'h55);
    tick;
    check_val("dw_N_tris_b", 32'(tris_b), 32'h0F);
    check_val("dw_N_ack", 32'(dbg_ack), 32'h0);
    tick;
    check_val("dw_N1_tris_b", 32'(tris_b), 32'h55);
    check_val("dw_N1_ack", 32'(dbg_ack), 32'h0);
    tick;
    check_val("dw_N2_ack", 32'(dbg_ack), 32'h1);
    check_val("dw_err", 32'(dbg_err), 32'h0);
    dbg_req = 0;
    tick;
    check_val("dw_N3_ack", 32'(dbg_ack), 32'h0);
    tick;

    // Debug write latch B colliding with core write of latch B
    dbg_start(1'b1, 3'd1, 8'h11);
    tick;
    cpu_wr_port = 1; cpu_sel = 2'b10; cpu_wdata = 8'h22;
    tick;
    cpu_wr_port = 0;
    check_val("cf_core_wins", 32'(port_b), 32'h22);
    check_val("cf_ack_N1", 32'(dbg_ack), 32'h0);
    tick;
    check_val("cf_dbg_after", 32'(port_b), 32'h11);
    check_val("cf_ack_N2", 32'(dbg_ack), 32'h0);
    tick;
    check_val("cf_ack_N3", 32'(dbg_ack), 32'h1);
    dbg_req = 0;
    tick;
    check_val("cf_ack_off", 32'(dbg_ack), 32'h0);
    tick;

    // Debug read of TRIS A (zero-extended)
    dbg_start(1'b0, 3'd4, 8'h00);
    repeat (3) tick;
    check_val("dr_ack", 32'(dbg_ack), 32'h1);
    check_val("dr_rdata", 32'(dbg_rdata), 32'h07);
    dbg_req = 0;
    repeat (2) tick;

    // Invalid address, request held high afterwards
    dbg_start(1'b0, 3'd7, 8'h00);
    repeat (3) tick;
    check_val("inv_ack", 32'(dbg_ack), 32'h1);
    check_val("inv_err", 32'(dbg_err), 32'h1);
    check_val("inv_rdata", 32'(dbg_rdata), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_val($sformatf("inv_hold_ack%0d", i), 32'(dbg_ack), 32'h0);
    end
    check_val("inv_regs", {port_b, tris_b, 4'h0, port_a, 4'h0, tris_a}, 32'h11550707);
    dbg_req = 0;
    repeat (2) tick;

    // Valid write clears the error flag
    dbg_start(1'b1, 3'd0, 8'hF6);
    repeat (3) tick;
    check_val("clr_ack", 32'(dbg_ack), 32'h1);
    check_val("clr_err", 32'(dbg_err), 32'h0);
    check_val("clr_port_a", 32'(port_a), 32'h6);
    dbg_req = 0;
    repeat (2) tick;

    // Asynchronous reset mid-transaction, request kept high
    dbg_start(1'b1, 3'd2, 8'h77);
    tick;
    #3 rst = 1'b1;
    #1;
    check_val("arst_tris_b", 32'(tris_b), 32'hFF);
    check_val("arst_ports", {8'h0, 4'(port_a), port_b, port_c}, 32'h0);
    check_val("arst_dbg", {dbg_ack, dbg_err, dbg_rdata}, 32'h0);
    tick;
    rst = 1'b0;
    tick;
    check_val("rr_N_port_c", 32'(port_c), 32'h0);
    tick;
    check_val("rr_N1_port_c", 32'(port_c), 32'h77);
    check_val("rr_N1_ack", 32'(dbg_ack), 32'h0);
    tick;
    check_val("rr_N2_ack", 32'(dbg_ack), 32'h1);
    dbg_req = 0;
    repeat (2) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
